// File: rtl/key_sched_pkg.sv
// Shared types and helpers for the AES key-schedule engine and the cipher datapath.
package key_sched_pkg;

  typedef logic [31:0] word_t;

  // LOAD is taken on the IDLE exit edge, so the FSM never rests in it.
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit forward AES S-box, shared with the cipher datapath.
module aes_sbox
  import key_sched_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte_c
);

  assign out_byte_c = sbox_byte(in_byte);

endmodule

// File: rtl/key_sched_seq.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock, with random-access round-key read.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes the word table and aborts expansion.
module key_sched_seq
  import key_sched_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  output logic                busy,
  output logic                done,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key,
  output logic                rd_valid
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = (NK == 4) ? NR_128 : ((NK == 6) ? NR_192 : NR_256);
  localparam int unsigned NW = 4 * NR + 4;
  localparam int unsigned IW = 6;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_sched_seq: KEY_BITS must be 128, 192 or 256");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  word_t         w_q [NW];
  word_t         w_d [NW];

  word_t         prev_w, temp_w, sbox_in, sbox_out;
  logic          rot_step, sub_step, zero_c;
  logic [IW-1:0] rd_base;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zero_c = zeroize;
`else
  assign zero_c = 1'b0;
`endif

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte    (sbox_in[8*b +: 8]),
      .out_byte_c (sbox_out[8*b +: 8])
    );
  end

  // Schedule-word transform applied to W[i-1].
  always_comb begin
    prev_w   = w_q[i_q - IW'(1)];
    rot_step = (i_q % IW'(NK)) == '0;
    sub_step = (NK == 8) && (i_q[2:0] == 3'd4);
    sbox_in  = rot_step ? rot_word(prev_w) : prev_w;
    if (rot_step) begin
      temp_w = sbox_out ^ {rcon_q, 24'h0};
    end else if (sub_step) begin
      temp_w = sbox_out;
    end else begin
      temp_w = prev_w;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    w_d     = w_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < NK; k++) begin
            w_d[IW'(k)] = 32'(key_in >> (KEY_BITS - 32 - 32 * k));
          end
          valid_d = 1'b0;
          i_d     = IW'(NK);
          rcon_d  = 8'h01;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        w_d[i_q] = w_q[i_q - IW'(NK)] ^ temp_w;
        i_d      = i_q + IW'(1);
        if (rot_step) rcon_d = xtime(rcon_q);
        if (i_q == IW'(NW - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Zeroize overrides everything, including a same-cycle start.
    if (zero_c) begin
      for (int unsigned k = 0; k < NW; k++) w_d[IW'(k)] = '0;
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= IW'(NK);
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Word table is deliberately left out of reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    rd_valid = valid_q && (rd_round <= 4'(NR));
    rd_base  = rd_valid ? {rd_round, 2'b00} : '0;
    rd_key   = rd_valid ? {w_q[rd_base], w_q[rd_base + IW'(1)],
                           w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]} : '0;
  end

endmodule

// File: tb/tb_key_sched_seq.sv
// Self-checking bench for key_sched_seq: one instance per key size, checked against a GF(2^8)-based key-expansion model.
module tb_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_s    [3];
  logic [255:0] key_s      [3];
  logic [3:0]   rd_round_s [3];
  logic         busy_s     [3];
  logic         done_s     [3];
  logic         rd_valid_s [3];
  logic [127:0] rd_key_s   [3];
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize_s  [3];
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] ref_w [60];

  always #5 clk = ~clk;

  key_sched_seq #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .key_in(key_s[0][127:0]),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize_s[0]),
`endif
    .busy(busy_s[0]), .done(done_s[0]), .rd_round(rd_round_s[0]),
    .rd_key(rd_key_s[0]), .rd_valid(rd_valid_s[0]));

  key_sched_seq #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .key_in(key_s[1][191:0]),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize_s[1]),
`endif
    .busy(busy_s[1]), .done(done_s[1]), .rd_round(rd_round_s[1]),
    .rd_key(rd_key_s[1]), .rd_valid(rd_valid_s[1]));

  key_sched_seq #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .key_in(key_s[2]),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize_s[2]),
`endif
    .busy(busy_s[2]), .done(done_s[2]), .rd_round(rd_round_s[2]),
    .rd_key(rd_key_s[2]), .rd_valid(rd_valid_s[2]));

  // ---------------- reference model: S-box from field inverse + affine map ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (b != 8'h00 && gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] model_subw(input logic [31:0] w);
    return {model_sbox(w[31:24]), model_sbox(w[23:16]), model_sbox(w[15:8]), model_sbox(w[7:0])};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int k = 0; k < nk; k++) ref_w[k] = key[32*(nk-k)-1 -: 32];
    for (int i = nk; i < 4 * (nk + 6) + 4; i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t = model_subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = model_subw(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Starts one expansion; start edge is E0, lat is the edge count after which done is seen.
  task automatic run_expand(input int sel, input logic [255:0] key, input bit inject,
                            output int lat, output logic busy1, output logic valid1);
    lat = -1; busy1 = 1'bx; valid1 = 1'bx;
    @(negedge clk);
    key_s[sel] = key; start_s[sel] = 1'b1; rd_round_s[sel] = 4'd0;
    @(posedge clk);
    #1 start_s[sel] = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (inject) begin
        start_s[sel] = (n == 4 || n == 39 || n == 40);
        key_s[sel]   = rand_key();
      end
      @(negedge clk);
      if (n == 1) begin busy1 = busy_s[sel]; valid1 = rd_valid_s[sel]; end
      if (done_s[sel]) begin lat = n; break; end
    end
    start_s[sel] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (busy_s[s] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_s[s]); else n_pass++;
      n_checks++; if (done_s[s] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", s, done_s[s]); else n_pass++;
      n_checks++; if (rd_valid_s[s] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", s, rd_valid_s[s]); else n_pass++;
      n_checks++; if (rd_key_s[s] !== 128'h0) $display("FAIL reset_key[%0d]: got %h want 0", s, rd_key_s[s]); else n_pass++;
    end
  endtask

  task automatic test_kat();
    int lat; logic b1, v1;
    int          lat_exp [3] = '{41, 47, 53};
    logic [255:0] kat    [3] = '{256'h2b7e151628aed2a6abf7158809cf4f3c,
                                 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4};
    for (int s = 0; s < 3; s++) begin
      run_expand(s, kat[s], 1'b0, lat, b1, v1);
      n_checks++; if (lat !== lat_exp[s]) $display("FAIL kat_latency[%0d]: got %0d want %0d", s, lat, lat_exp[s]); else n_pass++;
      n_checks++; if (b1 !== 1'b1) $display("FAIL kat_busy[%0d]: got %b want 1", s, b1); else n_pass++;
      n_checks++; if (v1 !== 1'b0) $display("FAIL kat_valid_before_done[%0d]: got %b want 0", s, v1); else n_pass++;
      @(negedge clk);
      n_checks++; if (done_s[s] !== 1'b0) $display("FAIL kat_done_width[%0d]: got %b want 0", s, done_s[s]); else n_pass++;
    end
    rd_round_s[0] = 4'd1; #1;
    n_checks++; if (rd_key_s[0] !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL aes128_r1: got %h want a0fafe1788542cb123a339392a6c7605", rd_key_s[0]); else n_pass++;
    rd_round_s[0] = 4'd10; #1;
    n_checks++; if (rd_key_s[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL aes128_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key_s[0]); else n_pass++;
    rd_round_s[1] = 4'd12; #1;
    n_checks++; if (rd_key_s[1][31:0] !== 32'h01002202) $display("FAIL aes192_w51: got %h want 01002202", rd_key_s[1][31:0]); else n_pass++;
    rd_round_s[1] = 4'd0; #1;
    n_checks++; if (rd_key_s[1] !== 128'h8e73b0f7da0e6452c810f32b809079e5) $display("FAIL aes192_r0: got %h want 8e73b0f7da0e6452c810f32b809079e5", rd_key_s[1]); else n_pass++;
    rd_round_s[2] = 4'd14; #1;
    n_checks++; if (rd_key_s[2][31:0] !== 32'h706c631e) $display("FAIL aes256_w59: got %h want 706c631e", rd_key_s[2][31:0]); else n_pass++;
    n_checks++; if (rd_valid_s[2] !== 1'b1) $display("FAIL aes256_valid_r14: got %b want 1", rd_valid_s[2]); else n_pass++;
  endtask

  task automatic test_bounds();
    int nr;
    for (int s = 0; s < 3; s++) begin
      nr = 10 + 2 * s;
      for (int r = nr + 1; r <= 15; r++) begin
        @(negedge clk); rd_round_s[s] = 4'(r); #1;
        n_checks++;
        if (rd_valid_s[s] !== 1'b0 || rd_key_s[s] !== 128'h0)
          $display("FAIL bounds[%0d] round %0d: got valid %b key %h, want valid 0 key 0", s, r, rd_valid_s[s], rd_key_s[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_keys();
    int lat; logic b1, v1; logic [255:0] key; logic [127:0] exp;
    int lat_exp [3] = '{41, 47, 53};
    for (int rep = 0; rep < 2; rep++) begin
      for (int s = 0; s < 3; s++) begin
        key = rand_key();
        run_expand(s, key, 1'b0, lat, b1, v1);
        n_checks++; if (lat !== lat_exp[s]) $display("FAIL rand_latency[%0d]: got %0d want %0d", s, lat, lat_exp[s]); else n_pass++;
        n_checks++; if (v1 !== 1'b0) $display("FAIL rand_valid_drop[%0d]: got %b want 0", s, v1); else n_pass++;
        model_expand(key, 4 + 2 * s);
        for (int r = 0; r <= 10 + 2 * s; r++) begin
          @(negedge clk); rd_round_s[s] = 4'(r); #1;
          exp = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
          n_checks++;
          if (rd_key_s[s] !== exp || rd_valid_s[s] !== 1'b1)
            $display("FAIL rand_key[%0d] round %0d: got %h valid %b, want %h valid 1", s, r, rd_key_s[s], rd_valid_s[s], exp);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat; logic b1, v1;
    run_expand(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, lat, b1, v1);
    n_checks++; if (lat !== 41) $display("FAIL ignore_latency: got %0d want 41", lat); else n_pass++;
    @(negedge clk); rd_round_s[0] = 4'd10; #1;
    n_checks++; if (rd_key_s[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL ignore_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key_s[0]); else n_pass++;
    n_checks++; if (busy_s[0] !== 1'b0) $display("FAIL ignore_idle: got busy %b want 0", busy_s[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat; logic b1, v1; logic seen; logic [255:0] key; logic [127:0] exp;
    @(negedge clk);
    key_s[0] = rand_key(); start_s[0] = 1'b1; rd_round_s[0] = 4'd0;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_s[0] !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_s[0]); else n_pass++;
    n_checks++; if (rd_valid_s[0] !== 1'b0) $display("FAIL midrst_valid: got %b want 0", rd_valid_s[0]); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (done_s[0]) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL midrst_no_done: got done %b want 0", seen); else n_pass++;
    key = rand_key();
    run_expand(0, key, 1'b0, lat, b1, v1);
    n_checks++; if (lat !== 41) $display("FAIL midrst_latency: got %0d want 41", lat); else n_pass++;
    model_expand(key, 4);
    for (int r = 0; r <= 10; r++) begin
      @(negedge clk); rd_round_s[0] = 4'(r); #1;
      exp = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
      n_checks++;
      if (rd_key_s[0] !== exp) $display("FAIL midrst_key round %0d: got %h want %h", r, rd_key_s[0], exp);
      else n_pass++;
    end
  endtask

`ifdef KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize();
    int lat; logic b1, v1; logic seen;
    @(negedge clk);
    key_s[0] = rand_key(); start_s[0] = 1'b1; rd_round_s[0] = 4'd1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 zeroize_s[0] = 1'b1;
    @(posedge clk);
    #1 zeroize_s[0] = 1'b0;
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (done_s[0]) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL zero_no_done: got done %b want 0", seen); else n_pass++;
    n_checks++; if (rd_valid_s[0] !== 1'b0) $display("FAIL zero_valid: got %b want 0", rd_valid_s[0]); else n_pass++;
    n_checks++; if (busy_s[0] !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy_s[0]); else n_pass++;
    run_expand(0, 256'h0, 1'b0, lat, b1, v1);
    n_checks++; if (lat !== 41) $display("FAIL zero_latency: got %0d want 41", lat); else n_pass++;
    @(negedge clk); rd_round_s[0] = 4'd1; #1;
    n_checks++; if (rd_key_s[0] !== 128'h62636363626363636263636362636363) $display("FAIL zero_r1: got %h want 62636363626363636263636362636363", rd_key_s[0]); else n_pass++;
    @(negedge clk); zeroize_s[0] = 1'b1;
    @(negedge clk); zeroize_s[0] = 1'b0;
    n_checks++; if (rd_valid_s[0] !== 1'b0) $display("FAIL zero_idle_valid: got %b want 0", rd_valid_s[0]); else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start_s[s] = 1'b0; key_s[s] = '0; rd_round_s[s] = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
      zeroize_s[s] = 1'b0;
`endif
    end
    test_reset();
    test_kat();
    test_bounds();
    test_random_keys();
    test_start_ignored();
    test_reset_mid_run();
`ifdef KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_sched_seq.md
Name: key_sched_seq

Overview:
- Iterative AES key-expansion engine; parametrised successor to the combinational 128-bit round-key generator.
- Supports AES-128/192/256 by parameter and generates one 32-bit schedule word per clock.
- Stores the full schedule in an internal word table and serves any round key through a random-access read port.
- Feeds the encrypt/decrypt datapath in EncDec, which reads round keys by index.

Parameters:
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256; any other value is an elaboration error.
- NK, KEY_BITS/32 (derived localparam), number of key words.
- NR, NK+6 (derived localparam), number of rounds (10/12/14).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request expansion of key_in; sampled only in IDLE.
- key_in  in  KEY_BITS  cipher key; MSB byte is key byte 0.
- busy  out  1  high in LOAD/EXPAND/DONE states.
- done  out  1  one-cycle pulse when the schedule is complete.
- rd_round  in  4  round-key index 0..NR.
- rd_key  out  128  round key rd_round; combinational read.
- rd_valid  out  1  schedule complete and rd_round <= NR.

Behaviour:
- Reset: state IDLE; busy=0, done=0, table-valid flag=0, Rcon register=8'h01. Word table is not cleared. rd_key reads 0 whenever rd_valid=0.
- FSM IDLE -> LOAD -> EXPAND -> DONE -> IDLE.
  - IDLE: start=1 at edge E0 writes W[0..NK-1] from key_in (W[0] = MSB word), clears table-valid, sets i=NK and Rcon=01, and moves to EXPAND. This is the LOAD action, taken on the same edge.
  - EXPAND: each edge writes W[i] and increments i.
    - temp=W[i-1].
    - If i mod NK==0: temp=SubWord(RotWord(temp)) ^ {Rcon,24'h0}, and Rcon advances by xtime (01,02,..,80,1b,36).
    - Else if NK==8 and i mod 8==4: temp=SubWord(temp).
    - W[i]=W[i-NK]^temp.
    - After W[4NR+3] is written, go to DONE.
  - DONE: for one cycle, done=1 and table-valid=1; then IDLE.
- Latency: done is high for the cycle following edge E0+4NR+5-NK. That is edge 41 for AES-128, 47 for AES-192, 53 for AES-256.
- start while busy: ignored, with no effect on the in-flight expansion. start in the DONE cycle is also ignored.
- New start in IDLE after a completed run: rd_valid drops on the LOAD edge, and old keys are not readable during re-expansion.
- rd_key = {W[4r],W[4r+1],W[4r+2],W[4r+3]} with W[4r] in bits 127:96. If rd_round > NR, rd_key=0 and rd_valid=0.
- rst_n low mid-expansion: FSM immediately goes to IDLE, table-valid=0, no done pulse. A fresh start is required.
- i counter width: 6 bits (max 59). Rcon uses an 8-bit register, not a lookup table.

Optional Feature:
- Macro KEY_SCHED_ZEROIZE_EN.
- Defined: adds input port zeroize (1 bit). zeroize=1 at any edge, in any state, clears every table word to 0, forces IDLE, clears table-valid, and suppresses done. zeroize has priority over start in the same cycle.
- Undefined: the port does not exist; table contents persist until overwritten.

Decomposition:
- Package key_sched_pkg holds:
  - typedef word_t (logic [31:0]);
  - state enum state_t {IDLE, LOAD, EXPAND, DONE};
  - function xtime;
  - functions rot_word and sub_word prototypes;
  - constants NR_128/192/256.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4x for SubWord. The same sbox is reused by the cipher datapath.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start at edge 0:
  - done pulses for exactly one cycle after edge 41;
  - rd_round=1 gives a0fafe1788542cb123a339392a6c7605;
  - rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after edge 47;
  - rd_round=12 low word (W[51]) = 01002202;
  - rd_round=0 = 8e73b0f7da0e6452c810f32b809079e5.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after edge 53;
  - rd_round=14 low word (W[59]) = 706c631e.
- Handshake/boundary:
  - start re-asserted at edges 5 and 40 of an AES-128 run is ignored, and the round-10 key is unchanged;
  - rd_round=11 gives rd_key=0, rd_valid=0;
  - before the first done, rd_valid=0.
- rst_n pulsed low at edge 20 of a run: busy=0 and rd_valid=0 asynchronously, with no done. A following start with a new key produces the correct schedule for that key.
- With KEY_SCHED_ZEROIZE_EN: zeroize during EXPAND leaves rd_valid=0. After a new run with key all-zero, round 1 = 62636363626363636263636362636363.
